// File: rtl/e_mdu_pkg.sv
// rtl/e_mdu_pkg.sv - MDU operation encodings and default latencies shared with the controller.
package MDU_Defs;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'b0000,
    MDU_MULT  = 4'b0001,
    MDU_MULTU = 4'b0010,
    MDU_DIV   = 4'b0011,
    MDU_DIVU  = 4'b0100,
    MDU_MFHI  = 4'b0101,
    MDU_MFLO  = 4'b0110,
    MDU_MTHI  = 4'b0111,
    MDU_MTLO  = 4'b1000
  } mdu_op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic is_start_op(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu_timer.sv
// rtl/e_mdu_timer.sv - busy countdown; commit pulses in the cycle the count leaves 1.
module MDU_Timer #(
  parameter int MULT_CYCLES = MDU_Defs::MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MDU_Defs::DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic load_div,
  output logic busy,
  output logic commit
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = (MAX_CYCLES < 1) ? 1 : $clog2(MAX_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy   = (cnt_q != '0);
  assign commit = (cnt_q == CW'(1));

endmodule

// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - E-stage multiply/divide unit with HI/LO registers and fixed-latency busy window.
module e_mdu
  import MDU_Defs::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] MDUIn1,
  input  logic [31:0] MDUIn2,
  input  logic [3:0]  MDUOp,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] MDURes
);

  logic        busy;
  logic        commit;
  logic        accept;

  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic        pend_wr_q, pend_wr_d;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        mag_a, mag_b, mag_b_safe, udiv_b_safe;
  logic [31:0]        sq, sr, sq_fix, sr_fix, uq, ur;

  assign accept = Start && !busy && is_start_op(MDUOp);

  MDU_Timer #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept),
    .load_div(is_div_op(MDUOp)),
    .busy    (busy),
    .commit  (commit)
  );

  // Signed division runs on magnitudes so 0x80000000 / -1 wraps back to 0x80000000 naturally.
  always_comb begin
    prod_s      = $signed({{32{MDUIn1[31]}}, MDUIn1}) * $signed({{32{MDUIn2[31]}}, MDUIn2});
    prod_u      = {32'd0, MDUIn1} * {32'd0, MDUIn2};
    mag_a       = MDUIn1[31] ? (32'd0 - MDUIn1) : MDUIn1;
    mag_b       = MDUIn2[31] ? (32'd0 - MDUIn2) : MDUIn2;
    mag_b_safe  = (mag_b == 32'd0) ? 32'd1 : mag_b;
    udiv_b_safe = (MDUIn2 == 32'd0) ? 32'd1 : MDUIn2;
    sq          = mag_a / mag_b_safe;
    sr          = mag_a % mag_b_safe;
    sq_fix      = (MDUIn1[31] ^ MDUIn2[31]) ? (32'd0 - sq) : sq;
    sr_fix      = MDUIn1[31] ? (32'd0 - sr) : sr;
    uq          = MDUIn1 / udiv_b_safe;
    ur          = MDUIn1 % udiv_b_safe;
  end

  always_comb begin
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    if (accept) begin
      pend_wr_d = 1'b1;
      case (MDUOp)
        MDU_MULT:  {pend_hi_d, pend_lo_d} = prod_s;
        MDU_MULTU: {pend_hi_d, pend_lo_d} = prod_u;
        MDU_DIV: begin
          pend_hi_d = sr_fix;
          pend_lo_d = sq_fix;
          pend_wr_d = (MDUIn2 != 32'd0);
        end
        default: begin
          pend_hi_d = ur;
          pend_lo_d = uq;
          pend_wr_d = (MDUIn2 != 32'd0);
        end
      endcase
    end
  end

  // A commit always lands while busy is high, so it can never collide with an accepted mthi/mtlo.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (commit) begin
      if (pend_wr_q) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
    end else if (!busy) begin
      if (MDUOp == MDU_MTHI) hi_d = MDUIn1;
      if (MDUOp == MDU_MTLO) lo_d = MDUIn1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  always_comb begin
    MDURes = 32'd0;
    if (MDUOp == MDU_MFHI) MDURes = hi_q;
    if (MDUOp == MDU_MFLO) MDURes = lo_q;
  end

  assign Busy = busy;

endmodule

// File: doc/e_mdu.md
E_MDU -- requirements
Module: E_MDU

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, giving the busy duration of mult/multu in cycles.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, giving the busy duration of div/divu in cycles.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-005 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have port MDUIn1, input, 32 bits, forwarded rs operand, same source as the ALU first operand.
REQ-007 SHALL have port MDUIn2, input, 32 bits, forwarded rt operand.
REQ-008 SHALL have port MDUOp, input, 4 bits, operation: 0000 none, 0001 mult, 0010 multu, 0011 div, 0100 divu, 0101 mfhi, 0110 mflo, 0111 mthi, 1000 mtlo.
REQ-009 SHALL have port Start, input, 1 bit, qualifies mult/multu/div/divu in the current E-stage cycle.
REQ-010 SHALL have port Busy, output, 1 bit, high while an operation is in flight.
REQ-011 SHALL have port MDURes, output, 32 bits, combinational mfhi/mflo read data.

Function
REQ-012 SHALL accept an operation only at a rising edge where Start=1, Busy=0, and MDUOp is 0001..0100; all other Start pulses are ignored.
REQ-013 SHALL, on acceptance at edge T, compute the full result into pending registers and load the countdown with MULT_CYCLES or DIV_CYCLES.
REQ-014 SHALL drive Busy = (countdown != 0), so Busy is high for exactly MULT_CYCLES or DIV_CYCLES cycles after edge T.
REQ-015 SHALL commit the pending values to HI and LO on the edge where the countdown goes from 1 to 0; the new values are visible in the same cycle that Busy falls.
REQ-016 SHALL compute mult as the signed 64-bit product {HI,LO} and multu as the unsigned 64-bit product.
REQ-017 SHALL compute div as LO = signed quotient truncated toward zero and HI = remainder carrying the sign of the dividend; divu uses unsigned quotient and remainder.
REQ-018 SHALL handle 0x80000000 div 0xFFFFFFFF as LO=0x80000000, HI=0.
REQ-019 SHALL, on division by zero, still run the full busy period and leave HI and LO unchanged.
REQ-020 SHALL, for mthi or mtlo with Busy=0, write MDUIn1 to HI or LO at the edge, and SHALL ignore mthi/mtlo while Busy=1.
REQ-021 SHALL drive MDURes = HI for mfhi, LO for mflo, and 0 otherwise; while Busy=1, reads return the pre-operation HI/LO.
REQ-022 SHALL apply precedence so that a commit and an mthi/mtlo never coincide; per REQ-020 the commit always wins.

Reset
REQ-023 SHALL, on rst_n low at any time including mid-operation, immediately clear HI, LO, the pending registers and the countdown, forcing Busy=0 and MDURes=0.
REQ-024 SHALL accept no operation while rst_n is low, and SHALL accept normally from the first rising edge after rst_n rises.

Structure
REQ-025 SHALL take the MDUOp encodings and the default latency constants from a shared package, MDU_Defs, that is also used by the controller.
REQ-026 SHALL contain one sub-module, MDU_Timer, holding the countdown and Busy generation; the arithmetic and HI/LO registers stay in E_MDU.

Verification
REQ-027 SHALL cover: mult 0xFFFFFFFF x 0x00000002 -> Busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu on the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-028 SHALL cover: div 0xFFFFFFF9 / 0x00000002 -> Busy high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 7 / 2 -> LO=3, HI=1.
REQ-029 SHALL cover: mthi 0x12345678, then div x / 0 -> after 10 busy cycles HI=0x12345678 and LO unchanged.
REQ-030 SHALL cover: with a mult in flight, Start+divu, mtlo 0xAAAAAAAA and mfhi -> all writes are ignored, mfhi returns the old HI, and the mult result commits on schedule.
REQ-031 SHALL cover: rst_n pulsed low in busy cycle 3 of a mult -> Busy=0, HI=LO=0 immediately; after release, mflo -> 0.
